// File: rtl/seg_update_if.sv
// Bundle of the two requester handshakes and the display-driver outputs
// of the seven-segment update arbiter.
//
// Handshake (both requesters): a source raises *_req with *_data stable
// and holds both until it sees a one-cycle *_ack; the word is latched on
// the same edge that produces the ack. Dropping *_req before the ack
// withdraws the request, and the word is then never latched.
interface seg_update_if #(
  parameter int DW = 32
);
  logic          cpu_req;
  logic [DW-1:0] cpu_data;
  logic          cpu_ack;
  logic          dbg_req;
  logic [DW-1:0] dbg_data;
  logic          dbg_ack;
  logic [DW-1:0] disp_data;
  logic          disp_en;
  logic          busy;
  logic          last_src;

  // Requester / display side
  modport master (
    output cpu_req, cpu_data, dbg_req, dbg_data,
    input  cpu_ack, dbg_ack, disp_data, disp_en, busy, last_src
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_data, dbg_req, dbg_data,
    output cpu_ack, dbg_ack, disp_data, disp_en, busy, last_src
  );
endinterface

// File: rtl/seg_update_arbiter.sv
// Round-robin arbiter sharing the seven-segment display between the CPU
// store path (source 0) and the debug/trap reporter (source 1). A grant
// latches the winner's word, pulses disp_en and the winner's ack for one
// cycle, then dwells HOLD_CYCLES cycles before requests are sampled again.
// Every output comes straight from a flop.
module seg_update_arbiter #(
  parameter logic [19:0] HOLD_CYCLES = 20'd100000,
  parameter int          DW          = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seg_update_if.slave  bus,
  output logic [1:0]   fsm_state_o,
  output logic         rr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [DW-1:0] disp_data_q, disp_data_d;
  logic          last_src_q, last_src_d;
  logic          disp_en_q, disp_en_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic          busy_q, busy_d;
  logic          winner;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    disp_data_d = disp_data_q;
    last_src_d  = last_src_q;
    disp_en_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    busy_d      = busy_q;
    winner      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.cpu_req || bus.dbg_req) begin
          // On a tie the round-robin pointer decides; otherwise the lone requester wins
          winner      = (bus.cpu_req && bus.dbg_req) ? rr_q : bus.dbg_req;
          disp_data_d = winner ? bus.dbg_data : bus.cpu_data;
          last_src_d  = winner;
          rr_d        = ~winner;
          disp_en_d   = 1'b1;
          cpu_ack_d   = ~winner;
          dbg_ack_d   = winner;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 20'd0;
        busy_d  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_CYCLES - 20'd1) begin
          cnt_d   = 20'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q + 20'd1;
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= 20'd0;
      disp_data_q <= '0;
      last_src_q  <= 1'b0;
      disp_en_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      disp_data_q <= disp_data_d;
      last_src_q  <= last_src_d;
      disp_en_q   <= disp_en_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.disp_data = disp_data_q;
  assign bus.last_src  = last_src_q;
  assign bus.disp_en   = disp_en_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.busy      = busy_q;
  assign fsm_state_o   = state_q;
  assign rr_o          = rr_q;

endmodule

// File: tb/tb_seg_update_arbiter.sv
// Bench for seg_update_arbiter with HOLD_CYCLES=4: directed scenarios,
// a per-cycle behavioural model of the display contract, and a grant
// scoreboard queue checked on every disp_en pulse.
module tb_seg_update_arbiter;
  localparam int          DW   = 32;
  localparam logic [19:0] HOLD = 20'd4;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;
  logic       rr;

  seg_update_if #(.DW(DW)) bus ();

  seg_update_arbiter #(.HOLD_CYCLES(HOLD), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fsm_state_o (fsm_state),
    .rr_o        (rr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The arbiter is "free" when dwell_left is 0; a grant makes it unavailable
  // for one load cycle plus HOLD dwell cycles.
  int unsigned   m_dwell_left;
  logic [DW-1:0] m_disp;
  logic          m_src, m_pref, m_en, m_cpu_ack, m_dbg_ack, m_busy;
  logic          m_valid = 1'b0;
  logic [DW:0]   exp_q[$];

  always @(posedge clk) begin
    logic win;
    m_en      = 1'b0;
    m_cpu_ack = 1'b0;
    m_dbg_ack = 1'b0;
    if (!rst_n) begin
      m_valid      = 1'b1;
      m_dwell_left = 0;
      m_disp       = '0;
      m_src        = 1'b0;
      m_pref       = 1'b0;
      m_busy       = 1'b0;
      exp_q.delete();
    end else if (m_dwell_left == 0 && (bus.cpu_req || bus.dbg_req)) begin
      win          = (bus.cpu_req && bus.dbg_req) ? m_pref : bus.dbg_req;
      m_disp       = win ? bus.dbg_data : bus.cpu_data;
      m_src        = win;
      m_pref       = !win;
      m_en         = 1'b1;
      m_cpu_ack    = !win;
      m_dbg_ack    = win;
      m_busy       = 1'b1;
      m_dwell_left = 32'(HOLD) + 1;
      exp_q.push_back({win, m_disp});
    end else if (m_dwell_left > 0) begin
      m_dwell_left = m_dwell_left - 1;
      m_busy       = (m_dwell_left != 0);
    end
  end

  // ---------------- compare process ----------------
  int   en_count      = 0;
  int   dbg_ack_count = 0;
  logic grant_log[$];

  always @(negedge clk) begin
    logic [DW:0] e;
    if (m_valid) begin
      check("disp_data", 64'(bus.disp_data), 64'(m_disp));
      check("disp_en",   64'(bus.disp_en),   64'(m_en));
      check("cpu_ack",   64'(bus.cpu_ack),   64'(m_cpu_ack));
      check("dbg_ack",   64'(bus.dbg_ack),   64'(m_dbg_ack));
      check("busy",      64'(bus.busy),      64'(m_busy));
      check("last_src",  64'(bus.last_src),  64'(m_src));
      check("ack_excl",  64'(bus.cpu_ack & bus.dbg_ack), 64'd0);
    end
    if (bus.dbg_ack === 1'b1) dbg_ack_count++;
    if (bus.disp_en === 1'b1) begin
      en_count++;
      grant_log.push_back(bus.last_src);
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("grant_scoreboard", 64'({bus.last_src, bus.disp_data}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  // Waits (sampling at negedge) for an ack; on expiry records a failure
  task automatic wait_ack(input logic src, output int at_cyc);
    int i;
    at_cyc = -1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((src == 1'b0 && bus.cpu_ack === 1'b1) || (src == 1'b1 && bus.dbg_ack === 1'b1)) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check(src ? "timeout_dbg_ack" : "timeout_cpu_ack", 64'd1, 64'd0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    if (bus.busy !== 1'b0) check("timeout_idle", 64'd1, 64'd0);
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t_cpu, t_dbg, n, acks_before;
    logic [DW-1:0] w;
    bus.cpu_req  = 1'b0;
    bus.dbg_req  = 1'b0;
    bus.cpu_data = '0;
    bus.dbg_data = '0;
    rst_n        = 1'b0;

    // Reset then idle
    do_reset(3);
    repeat (5) tick();
    @(negedge clk);
    check("idle_en_count",  64'(en_count),      64'd0);
    check("idle_disp_data", 64'(bus.disp_data), 64'd0);
    check("idle_busy",      64'(bus.busy),      64'd0);
    check("idle_acks",      64'({bus.cpu_ack, bus.dbg_ack, bus.last_src}), 64'd0);
    tick();

    // Single CPU write
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 32'h1234_ABCD;
    wait_ack(1'b0, t_cpu);
    bus.cpu_req = 1'b0;
    check("single_disp_en",   64'(bus.disp_en),   64'd1);
    check("single_disp_data", 64'(bus.disp_data), 64'h1234_ABCD);
    check("single_last_src",  64'(bus.last_src),  64'd0);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_len", 64'(n), 64'd5);
    tick();

    // Simultaneous requests from reset: CPU first, debug 6 cycles later
    do_reset(1);
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 32'h1111_1111;
    bus.dbg_req  = 1'b1;
    bus.dbg_data = 32'h2222_2222;
    wait_ack(1'b0, t_cpu);
    bus.cpu_req = 1'b0;
    check("simul_first_data", 64'(bus.disp_data), 64'h1111_1111);
    wait_ack(1'b1, t_dbg);
    bus.dbg_req = 1'b0;
    check("simul_spacing",     64'(t_dbg - t_cpu),  64'd6);
    check("simul_second_data", 64'(bus.disp_data), 64'h2222_2222);
    check("simul_second_src",  64'(bus.last_src),  64'd1);
    wait_idle();

    // Fairness under saturation: both held for 6 grants
    do_reset(1);
    grant_log.delete();
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 32'hC0C0_0000;
    bus.dbg_req  = 1'b1;
    bus.dbg_data = 32'hD0D0_0001;
    n = 0;
    while (grant_log.size() < 6 && n < 200) begin
      n++;
      @(negedge clk);
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    check("fair_count", 64'(grant_log.size()), 64'd6);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("fair_order", 64'(grant_log[i]), 64'(i % 2));
    end
    wait_idle();

    // Withdrawal: debug pulses for 2 cycles during CPU hold
    acks_before = dbg_ack_count;
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 32'hCAFE_0001;
    wait_ack(1'b0, t_cpu);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    bus.dbg_req  = 1'b1;
    bus.dbg_data = 32'hBAD0_BAD0;
    tick();
    tick();
    bus.dbg_req = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("withdraw_no_ack", 64'(dbg_ack_count - acks_before), 64'd0);
    check("withdraw_data",   64'(bus.disp_data), 64'hCAFE_0001);
    tick();

    // Reset mid-hold with debug request held
    bus.cpu_req  = 1'b1;
    bus.cpu_data = 32'h5555_AAAA;
    wait_ack(1'b0, t_cpu);
    bus.cpu_req  = 1'b0;
    w            = 32'hDEAD_BEEF;
    bus.dbg_data = w;
    bus.dbg_req  = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_data", 64'(bus.disp_data), 64'd0);
    check("rst_hold_busy", 64'(bus.busy),      64'd0);
    check("rst_hold_rr",   64'(rr),            64'd0);
    @(negedge clk);
    check("rst_regrant_ack",  64'(bus.dbg_ack),   64'd1);
    check("rst_regrant_data", 64'(bus.disp_data), 64'hDEAD_BEEF);
    check("rst_regrant_src",  64'(bus.last_src),  64'd1);
    check("rst_regrant_rr",   64'(rr),            64'd0);
    bus.dbg_req = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_update_arbiter.md
# seg_update_arbiter

Shares the 8-digit seven-segment display between two writers: the CPU MMIO store path and the debug/trap reporter. It grants one requester at a time using round-robin and latches the granted word. It presents the word to the display driver as `disp_data` with a one-cycle `disp_en` strobe, then holds it for a minimum dwell so every value stays readable before the next update.

## Interface
- `HOLD_CYCLES`, default 20'd100000, minimum dwell in `clk` cycles after each update; legal range 1..2^20-1.
- `DW`, default 32, width of the display word.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU requests a display update; held until `cpu_ack`.
- `cpu_data`  in  DW  CPU word; stable while `cpu_req` is high.
- `cpu_ack`  out  1  one-cycle grant/accept pulse to the CPU.
- `dbg_req`  in  1  debug source requests a display update; held until `dbg_ack`.
- `dbg_data`  in  DW  debug word; stable while `dbg_req` is high.
- `dbg_ack`  out  1  one-cycle grant/accept pulse to the debug source.
- `disp_data`  out  DW  word for the display driver; holds its value between updates.
- `disp_en`  out  1  one-cycle load strobe to the display driver.
- `busy`  out  1  high while an update is loading or dwelling.
- `last_src`  out  1  source of the current `disp_data`: 0 = CPU, 1 = debug.

## Operation
- FSM states: IDLE, LOAD, HOLD. The round-robin pointer `rr` holds the preferred source (0 = CPU, 1 = debug).
- IDLE, no request: stay in IDLE.
- IDLE, exactly one `*_req` high: grant that source.
- IDLE, both `*_req` high: grant the source named by `rr`.
- On the grant edge:
  - `disp_data` <= the winner's data.
  - `last_src` <= winner.
  - `rr` <= the other source.
  - Next state is LOAD.
- LOAD, exactly one cycle:
  - `disp_en` = 1.
  - The winner's ack = 1; the other ack = 0.
  - `busy` = 1.
  - Next state is HOLD; dwell counter cleared to 0.
- HOLD:
  - `busy` = 1; counter increments each cycle.
  - When counter == HOLD_CYCLES-1, go to IDLE.
  - Requests arriving during HOLD wait; they are not acked and not latched.
- Requests are sampled only in IDLE.
- A requester that drops `req` before its ack has withdrawn: no ack is given and its data is never latched.
- Counter width is 20 bits; it never wraps, because it exits at HOLD_CYCLES-1.
- `disp_data` changes only on a grant edge and never glitches in between.
- The `*_ack` outputs are mutually exclusive.
- A requester that holds `req` continuously is re-granted only after the FSM returns to IDLE. It then loses any tie to the other source.

## Timing
- Reset (`rst_n` low at a rising edge) sets, on that edge:
  - state IDLE.
  - `disp_data` = 0, `disp_en` = 0.
  - `cpu_ack` = 0, `dbg_ack` = 0.
  - `busy` = 0.
  - `last_src` = 0, `rr` = 0 (CPU preferred).
  - counter = 0.
- Reset mid-LOAD or mid-HOLD aborts the update; outstanding requests are re-arbitrated from IDLE after release.
- Reset in LOAD: any ack due that cycle is suppressed, so the requester must keep `req` high and is granted later.
- Latency: `req` sampled high in IDLE at edge N gives `disp_en`, ack and new `disp_data` visible in cycle N+1.
- Minimum spacing between consecutive `disp_en` pulses is HOLD_CYCLES+2 cycles: LOAD, HOLD_CYCLES cycles of HOLD, then one IDLE.
- All outputs are registered; there is no combinational path from any `*_req` to any output.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles, release with no requests.
  -> all outputs 0; `disp_en` never pulses.
- Single CPU write, HOLD_CYCLES=4: `cpu_req`=1, `cpu_data`=32'h1234_ABCD.
  -> next cycle `disp_en`=1, `cpu_ack`=1, `disp_data`=32'h1234_ABCD, `last_src`=0.
  -> `busy` stays high for 5 cycles in total, then 0.
- Simultaneous requests: `cpu_data`=32'h1111_1111 and `dbg_data`=32'h2222_2222, both held, HOLD_CYCLES=4.
  -> CPU is granted first.
  -> debug is granted exactly 6 cycles later; `disp_data`=32'h2222_2222, `last_src`=1.
- Fairness under saturation: both requesters re-request immediately after each ack, for 6 grants.
  -> grant order strictly alternates CPU, debug, CPU, debug, CPU, debug.
- Withdrawal: `dbg_req` pulses high for 2 cycles during a CPU HOLD, then drops before IDLE.
  -> no `dbg_ack`; `disp_data` keeps the CPU value.
- Reset mid-HOLD: `rst_n`=0 for 1 cycle in the 2nd HOLD cycle while `dbg_req` is held.
  -> `disp_data`=0 after reset.
  -> debug is granted 1 cycle after reset is released; `rr` preference returns to CPU.
